// File: rtl/armleocpu_ptw.sv
// armleocpu_ptw: Sv32 page-table walker returning PPN and PTE access bits (D,A,G,U,X,W,R,V) on a TLB miss
module armleocpu_ptw (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        resolve_ack,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        m_transaction,
  output logic [33:0] m_address,
  input  logic        m_transaction_done,
  input  logic [1:0]  m_transaction_response,
  input  logic [31:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state_q;
  logic level_q;
  logic [19:0] va_q;
  logic [21:0] ppn_q;
  logic af, pf, leaf, fin, unused_rsw;
  logic [9:0] vpn_sel;
  assign unused_rsw = ^m_rdata[9:8];
  assign vpn_sel = level_q ? va_q[19:10] : va_q[9:0];
  assign leaf = m_rdata[1] | m_rdata[3];
  assign af = m_transaction_response != 2'b00;
  assign pf = !af & (!m_rdata[0] | (!m_rdata[1] & m_rdata[2]) |
              (leaf & level_q & (|m_rdata[19:10])) | (!leaf & !level_q));
  assign fin = af | pf | leaf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= 1'b1;
      va_q <= '0;
      ppn_q <= '0;
      resolve_ack <= 1'b0;
      resolve_done <= 1'b0;
      resolve_pagefault <= 1'b0;
      resolve_accessfault <= 1'b0;
      resolve_physical_address <= '0;
      resolve_access_bits <= '0;
      m_transaction <= 1'b0;
      m_address <= '0;
    end else begin
      resolve_ack <= 1'b0;
      resolve_done <= 1'b0;
      case (state_q)
        IDLE: if (resolve_request) begin
          va_q <= resolve_virtual_address;
          ppn_q <= satp_ppn;
          level_q <= 1'b1;
          resolve_ack <= 1'b1;
          resolve_pagefault <= 1'b0;
          resolve_accessfault <= 1'b0;
          resolve_physical_address <= '0;
          resolve_access_bits <= '0;
          state_q <= FETCH;
        end
        FETCH: if (!m_transaction) begin
          m_transaction <= 1'b1;
          m_address <= {ppn_q, vpn_sel, 2'b00};
        end else if (m_transaction_done) begin
          m_transaction <= 1'b0;
          if (fin) begin
            state_q <= DONE;
            resolve_done <= 1'b1;
            resolve_accessfault <= af;
            resolve_pagefault <= pf;
            resolve_access_bits <= (af | pf) ? 8'h00 : m_rdata[7:0];
            resolve_physical_address <= (af | pf) ? 22'h0 :
              level_q ? {m_rdata[31:20], va_q[9:0]} : m_rdata[31:10];
          end else begin
            // pointer PTE at level 1: descend to level 0 through the next PPN
            ppn_q <= m_rdata[31:10];
            level_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_ptw.sv
// tb_armleocpu_ptw: table-driven self-checking bench for the Sv32 page-table walker
module tb_armleocpu_ptw;
  logic clk = 0, rst = 1;
  logic resolve_request = 0;
  logic [19:0] resolve_virtual_address = 0;
  logic [21:0] satp_ppn = 0;
  logic resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0] resolve_access_bits;
  logic m_transaction;
  logic [33:0] m_address;
  logic m_transaction_done = 0;
  logic [1:0] m_transaction_response = 0;
  logic [31:0] m_rdata = 0;
  int tests = 0, fails = 0, txn_cnt = 0, done_cnt = 0;

  armleocpu_ptw dut (
    .clk(clk), .rst(rst),
    .resolve_request(resolve_request),
    .resolve_virtual_address(resolve_virtual_address),
    .satp_ppn(satp_ppn),
    .resolve_ack(resolve_ack),
    .resolve_done(resolve_done),
    .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault),
    .resolve_physical_address(resolve_physical_address),
    .resolve_access_bits(resolve_access_bits),
    .m_transaction(m_transaction),
    .m_address(m_address),
    .m_transaction_done(m_transaction_done),
    .m_transaction_response(m_transaction_response),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_transaction && m_transaction_done) txn_cnt <= txn_cnt + 1;
    if (resolve_done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [31:0] p1;
    logic [1:0]  r1;
    logic [31:0] p0;
    logic [1:0]  r0;
    logic [33:0] a2;
    int          ntx;
    int          waits;
    logic [21:0] pa;
    logic [7:0]  ab;
    logic        pf;
    logic        af;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic walk(input vec_t v, input string tag);
    int t;
    bit finished;
    logic [33:0] a0;
    finished = 0;
    @(negedge clk);
    txn_cnt = 0;
    done_cnt = 0;
    resolve_request = 1;
    resolve_virtual_address = 20'h00403;
    satp_ppn = 22'h000001;
    @(negedge clk);
    chk({tag, " ack"}, resolve_ack, 1);
    chk({tag, " mtx_after_ack"}, m_transaction, 0);
    resolve_request = 0;
    for (int k = 0; k < 2 && !finished; k++) begin
      t = 0;
      while (!m_transaction && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!m_transaction) begin
        chk({tag, " mtx_timeout"}, 0, 1);
        break;
      end
      chk({tag, k == 0 ? " addr1" : " addr2"}, m_address, k == 0 ? 34'h1004 : v.a2);
      a0 = m_address;
      for (int w = 0; w < v.waits; w++) begin
        @(negedge clk);
        chk({tag, " addr_stable"}, {m_transaction, m_address}, {1'b1, a0});
      end
      m_transaction_done = 1;
      m_rdata = k == 0 ? v.p1 : v.p0;
      m_transaction_response = k == 0 ? v.r1 : v.r0;
      @(negedge clk);
      m_transaction_done = 0;
      m_rdata = 0;
      m_transaction_response = 0;
      chk({tag, " mtx_drop"}, m_transaction, 0);
      if (resolve_done) finished = 1;
    end
    chk({tag, " done"}, finished, 1);
    chk({tag, " pa"}, resolve_physical_address, v.pa);
    chk({tag, " ab"}, resolve_access_bits, v.ab);
    chk({tag, " pf"}, resolve_pagefault, v.pf);
    chk({tag, " af"}, resolve_accessfault, v.af);
    @(negedge clk);
    chk({tag, " done_low"}, resolve_done, 0);
    chk({tag, " txn_cnt"}, txn_cnt, v.ntx);
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " pa_hold"}, resolve_physical_address, v.pa);
  endtask

  initial begin
    vt[0] = '{32'h00000801, 2'b00, 32'h048D14DF, 2'b00, 34'h200C, 2, 0, 22'h012345, 8'hDF, 1'b0, 1'b0};
    vt[1] = '{32'h00000801, 2'b00, 32'h048D14DF, 2'b00, 34'h200C, 2, 1, 22'h012345, 8'hDF, 1'b0, 1'b0};
    vt[2] = '{32'h00000801, 2'b00, 32'h048D14DF, 2'b00, 34'h200C, 2, 7, 22'h012345, 8'hDF, 1'b0, 1'b0};
    vt[3] = '{32'h005000CF, 2'b00, 32'h0,        2'b00, 34'h0,    1, 0, 22'h001403, 8'hCF, 1'b0, 1'b0};
    vt[4] = '{32'h005004CF, 2'b00, 32'h0,        2'b00, 34'h0,    1, 1, 22'h0,      8'h00, 1'b1, 1'b0};
    vt[5] = '{32'h00000005, 2'b00, 32'h0,        2'b00, 34'h0,    1, 0, 22'h0,      8'h00, 1'b1, 1'b0};
    vt[6] = '{32'h00000000, 2'b00, 32'h0,        2'b00, 34'h0,    1, 0, 22'h0,      8'h00, 1'b1, 1'b0};
    vt[7] = '{32'h00000801, 2'b00, 32'h00000C01, 2'b00, 34'h200C, 2, 0, 22'h0,      8'h00, 1'b1, 1'b0};
    vt[8] = '{32'h00000801, 2'b11, 32'h0,        2'b00, 34'h0,    1, 0, 22'h0,      8'h00, 1'b0, 1'b1};
    vt[9] = '{32'h00000801, 2'b00, 32'h00000005, 2'b00, 34'h200C, 2, 2, 22'h0,      8'h00, 1'b1, 1'b0};
    @(negedge clk);
    chk("reset_state", {resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        m_transaction, m_address, resolve_physical_address, resolve_access_bits}, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) walk(vt[i], $sformatf("v%0d", i));
    // reset in the middle of a fetch
    @(negedge clk);
    done_cnt = 0;
    resolve_request = 1;
    resolve_virtual_address = 20'h00403;
    satp_ppn = 22'h000001;
    @(negedge clk);
    resolve_request = 0;
    @(negedge clk);
    chk("rst_pre_mtx", m_transaction, 1);
    rst = 1;
    #1;
    chk("rst_async", {resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        m_transaction, m_address, resolve_physical_address, resolve_access_bits}, 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_idle_mtx", m_transaction, 0);
    walk(vt[0], "post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
